// File: rtl/pipe_hazard_pkg.sv
// Shared types and defaults for the pipeline hazard scoreboard.
package pipe_hazard_pkg;

    localparam int unsigned NUM_REGS_DEF   = 16;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned LOAD_READY_DEF = 1;
    // Tag fields are stored at a fixed width so one struct serves any NUM_REGS up to 256.
    localparam int unsigned REG_W_MAX      = 8;
    localparam int unsigned FWD_RF         = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 is_load;
        logic [REG_W_MAX-1:0] dest;
        logic [REG_W_MAX-1:0] src1;
        logic [REG_W_MAX-1:0] src2;
        logic                 two_src;
    } sb_entry_t;

    // True when entry e will write register src.
    function automatic logic produces(input sb_entry_t e, input logic [REG_W_MAX-1:0] src);
        return e.valid && e.wb_en && (e.dest == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_match.sv
// Per-entry comparator: does this in-flight writer feed the given source pair.
module sb_stage_match #(
    parameter int unsigned W = 8
) (
    input  logic         valid,
    input  logic         wb_en,
    input  logic         is_load,
    input  logic [W-1:0] dest,
    input  logic [W-1:0] src1,
    input  logic [W-1:0] src2,
    input  logic         two_src,
    output logic         match1,
    output logic         match2,
    output logic         load_match
);

    assign match1     = valid && wb_en && (dest == src1);
    assign match2     = valid && wb_en && two_src && (dest == src2);
    assign load_match = is_load && (match1 || match2);

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: ID-stage stall and EXE forward selects.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / fwd_cnt counters.
module pipe_hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter  int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter  int unsigned DEPTH      = DEPTH_DEF,
    parameter  int unsigned LOAD_READY = LOAD_READY_DEF,
    localparam int unsigned REG_W      = $clog2(NUM_REGS),
    localparam int unsigned SEL_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fw_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_dest,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel1,
`ifdef HAZARD_STATS_EN
    output logic [SEL_W-1:0] fwd_sel2,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`else
    output logic [SEL_W-1:0] fwd_sel2
`endif
);

    sb_entry_t ent [DEPTH];
    sb_entry_t new_ent;

    logic [REG_W_MAX-1:0] id_s1_w;
    logic [REG_W_MAX-1:0] id_s2_w;
    logic [DEPTH-1:0]     id_m1;
    logic [DEPTH-1:0]     id_m2;
    logic [DEPTH-1:0]     id_lm;

    assign id_s1_w = REG_W_MAX'(id_src1);
    assign id_s2_w = REG_W_MAX'(id_src2);

    // Compare the ID operands against every tracked writer.
    for (genvar k = 0; k < DEPTH; k++) begin : g_match
        sb_stage_match #(.W(REG_W_MAX)) u_match (
            .valid      (ent[k].valid),
            .wb_en      (ent[k].wb_en),
            .is_load    (ent[k].is_load),
            .dest       (ent[k].dest),
            .src1       (id_s1_w),
            .src2       (id_s2_w),
            .two_src    (id_two_src),
            .match1     (id_m1[k]),
            .match2     (id_m2[k]),
            .load_match (id_lm[k])
        );
    end

    // Stall: any producer without forwarding, only not-yet-ready loads with it.
    always_comb begin
        logic raw_any;
        logic load_early;
        raw_any    = 1'b0;
        load_early = 1'b0;
        stall      = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            raw_any = raw_any | id_m1[k] | id_m2[k];
            if (k < LOAD_READY) begin
                load_early = load_early | id_lm[k];
            end
        end
        if (id_valid && !flush) begin
            stall = fw_en ? load_early : raw_any;
        end
    end

    // Entry entering EXE; bubble when stalled, flushed or empty.
    always_comb begin
        new_ent = '0;
        if (id_valid && !flush && !stall) begin
            new_ent.valid   = 1'b1;
            new_ent.wb_en   = id_wb_en;
            new_ent.is_load = id_is_load;
            new_ent.dest    = REG_W_MAX'(id_dest);
            new_ent.src1    = id_s1_w;
            new_ent.src2    = id_s2_w;
            new_ent.two_src = id_two_src;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent[k] <= '0;
            end
        end else begin
            ent[0] <= new_ent;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent[k] <= ent[k-1];
            end
        end
    end

    // Forward selects; scanning oldest to youngest lets the youngest producer win.
    always_comb begin
        fwd_sel1 = SEL_W'(FWD_RF);
        fwd_sel2 = SEL_W'(FWD_RF);
        if (fw_en && ent[0].valid) begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                if (produces(ent[k], ent[0].src1)) begin
                    fwd_sel1 = SEL_W'(k);
                end
                if (ent[0].two_src && produces(ent[k], ent[0].src2)) begin
                    fwd_sel2 = SEL_W'(k);
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic fwd_active;
    assign fwd_active = (fwd_sel1 != SEL_W'(FWD_RF)) || (fwd_sel2 != SEL_W'(FWD_RF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
            fwd_cnt   <= 32'd0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (fwd_active && (fwd_cnt != 32'hFFFF_FFFF)) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
